// File: rtl/mp_cond_subtractor.sv
// Chunked conditional subtractor for the last step of a Montgomery multiply: returns X - M when X >= M, else X.
// Optional MPSUB_ITERATE_EN: keep subtracting M (up to MAX_PASS commits) so guard-bit-sized X values are fully reduced.
module mp_cond_subtractor #(
   parameter int DATA_W   = 512,
   parameter int IN_W     = 514,
   parameter int CHUNK_W  = 103,
   parameter int NCHUNK   = 5,
   parameter int MAX_PASS = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [IN_W-1:0]   in_x,
   input  logic [DATA_W-1:0] in_m,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              subtracted,
   output logic [2:0]        pass_cnt
);

   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int LAST_W = IN_W - (NCHUNK - 1) * CHUNK_W;

`ifdef MPSUB_ITERATE_EN
   localparam bit ITERATE = 1'b1;
`else
   localparam bit ITERATE = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SUB, CHECK, DONE} state_t;

   state_t              state_q;
   logic [2:0]          k_q;
   logic                borrow_q;
   logic [PAD_W-1:0]    x_q;
   logic [PAD_W-1:0]    m_q;
   logic [PAD_W-1:0]    diff_q;
   logic                busy_q;
   logic                done_q;
   logic [DATA_W-1:0]   result_q;
   logic                subtracted_q;
   logic [2:0]          pass_cnt_q;

   int                  chunkBase;
   logic [CHUNK_W:0]    chunkDiff_d;
   logic                borrow_d;

   // The last chunk is one bit narrower, so its borrow sits one position lower.
   always_comb begin
      chunkBase   = int'(k_q) * CHUNK_W;
      chunkDiff_d = {1'b0, x_q[chunkBase +: CHUNK_W]} - {1'b0, m_q[chunkBase +: CHUNK_W]}
                    - {{CHUNK_W{1'b0}}, borrow_q};
      borrow_d    = (k_q == 3'(NCHUNK - 1)) ? chunkDiff_d[LAST_W] : chunkDiff_d[CHUNK_W];
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q      <= IDLE;
         k_q          <= '0;
         borrow_q     <= 1'b0;
         x_q          <= '0;
         m_q          <= '0;
         diff_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
         subtracted_q <= 1'b0;
         pass_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q          <= PAD_W'(in_x);
                  m_q          <= PAD_W'(in_m);
                  k_q          <= '0;
                  borrow_q     <= 1'b0;
                  subtracted_q <= 1'b0;
                  pass_cnt_q   <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= SUB;
               end
            end
            SUB: begin
               diff_q[chunkBase +: CHUNK_W] <= chunkDiff_d[CHUNK_W-1:0];
               borrow_q <= borrow_d;
               if (k_q == 3'(NCHUNK - 1)) begin
                  state_q <= CHECK;
               end else begin
                  k_q <= k_q + 3'd1;
               end
            end
            CHECK: begin
               if (borrow_q) begin
                  result_q <= x_q[DATA_W-1:0];
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  subtracted_q <= 1'b1;
                  pass_cnt_q   <= pass_cnt_q + 3'd1;
                  // Iterating: the committed difference becomes the new minuend for another pass.
                  if (ITERATE && ((pass_cnt_q + 3'd1) < 3'(MAX_PASS))) begin
                     x_q      <= diff_q;
                     k_q      <= '0;
                     borrow_q <= 1'b0;
                     state_q  <= SUB;
                  end else begin
                     result_q <= diff_q[DATA_W-1:0];
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign result     = result_q;
   assign subtracted = subtracted_q;
   assign pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_mp_cond_subtractor.sv
// Directed-vector bench for mp_cond_subtractor; expected values are hand computed for both build variants.
module tb_mp_cond_subtractor;

   logic         clk;
   logic         resetn;
   logic         start;
   logic [513:0] in_x;
   logic [511:0] in_m;
   logic         busy;
   logic         done;
   logic [511:0] result;
   logic         subtracted;
   logic [2:0]   pass_cnt;

   int errors;
   int checks;

   mp_cond_subtractor dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .in_x       (in_x),
      .in_m       (in_m),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .subtracted (subtracted),
      .pass_cnt   (pass_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses start for one cycle and counts cycles until done; lat = -1 on timeout.
   task automatic applyStimulus(input logic [513:0] x, input logic [511:0] m, output int lat);
      @(negedge clk);
      start = 1'b1;
      in_x  = x;
      in_m  = m;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset;
      resetn = 1'b1;
      start  = 1'b0;
      in_x   = '0;
      in_m   = '0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
      if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %0h expected 0", result); end
      if (subtracted !== 1'b0) begin errors++; $display("[TB] FAIL reset_sub: got %0b expected 0", subtracted); end
      if (pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_pcnt: got %0d expected 0", pass_cnt); end
      resetn = 1'b0;
   endtask

   task automatic test_basic;
      int lat;
      int expLat;
      logic [511:0] expRes;
      logic [2:0] expCnt;
`ifdef MPSUB_ITERATE_EN
      expRes = 512'd6; expCnt = 3'd2; expLat = 19;
`else
      expRes = 512'd13; expCnt = 3'd1; expLat = 7;
`endif
      applyStimulus(514'd20, 512'd7, lat);
      checks += 4;
      if (lat !== expLat) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, expLat); end
      if (result !== expRes) begin errors++; $display("[TB] FAIL basic_result: got %0h expected %0h", result, expRes); end
      if (subtracted !== 1'b1) begin errors++; $display("[TB] FAIL basic_sub: got %0b expected 1", subtracted); end
      if (pass_cnt !== expCnt) begin errors++; $display("[TB] FAIL basic_pcnt: got %0d expected %0d", pass_cnt, expCnt); end
   endtask

   task automatic test_reset_abort;
      int lat;
      int expLat;
      bit sawDone;
`ifdef MPSUB_ITERATE_EN
      expLat = 19;
`else
      expLat = 7;
`endif
      @(negedge clk);
      start = 1'b1;
      in_x  = 514'd20;
      in_m  = 512'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks += 1;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_pre: got %0b expected 1", busy); end
      resetn = 1'b1;
      @(negedge clk);
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %0b expected 0", done); end
      if (result !== '0) begin errors++; $display("[TB] FAIL abort_result: got %0h expected 0", result); end
      if (subtracted !== 1'b0) begin errors++; $display("[TB] FAIL abort_sub: got %0b expected 0", subtracted); end
      if (pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL abort_pcnt: got %0d expected 0", pass_cnt); end
      resetn  = 1'b0;
      sawDone = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
      end
      checks += 1;
      if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %0b expected 0", sawDone); end
      applyStimulus(514'd20, 512'd7, lat);
      checks += 2;
      if (lat !== expLat) begin errors++; $display("[TB] FAIL abort_rerun_lat: got %0d expected %0d", lat, expLat); end
`ifdef MPSUB_ITERATE_EN
      if (result !== 512'd6) begin errors++; $display("[TB] FAIL abort_rerun_result: got %0h expected 6", result); end
`else
      if (result !== 512'd13) begin errors++; $display("[TB] FAIL abort_rerun_result: got %0h expected d", result); end
`endif
   endtask

   task automatic test_no_sub;
      int lat;
      applyStimulus(514'd5, 512'd7, lat);
      checks += 4;
      if (lat !== 7) begin errors++; $display("[TB] FAIL nosub_latency: got %0d expected 7", lat); end
      if (result !== 512'd5) begin errors++; $display("[TB] FAIL nosub_result: got %0h expected 5", result); end
      if (subtracted !== 1'b0) begin errors++; $display("[TB] FAIL nosub_sub: got %0b expected 0", subtracted); end
      if (pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL nosub_pcnt: got %0d expected 0", pass_cnt); end
   endtask

   task automatic test_equal;
      int lat;
      int expLat;
      logic [513:0] x;
`ifdef MPSUB_ITERATE_EN
      expLat = 13;
`else
      expLat = 7;
`endif
      x      = '0;
      x[511] = 1'b1;
      x[0]   = 1'b1;
      applyStimulus(x, x[511:0], lat);
      checks += 4;
      if (lat !== expLat) begin errors++; $display("[TB] FAIL equal_latency: got %0d expected %0d", lat, expLat); end
      if (result !== '0) begin errors++; $display("[TB] FAIL equal_result: got %0h expected 0", result); end
      if (subtracted !== 1'b1) begin errors++; $display("[TB] FAIL equal_sub: got %0b expected 1", subtracted); end
      if (pass_cnt !== 3'd1) begin errors++; $display("[TB] FAIL equal_pcnt: got %0d expected 1", pass_cnt); end
   endtask

   task automatic test_ripple;
      int lat;
      int expLat;
      logic [513:0] x;
      logic [511:0] expRes;
      logic [2:0] expCnt;
      x      = '0;
      x[412] = 1'b1;
`ifdef MPSUB_ITERATE_EN
      expRes = x[511:0] - 512'd4; expCnt = 3'd4; expLat = 25;
`else
      expRes = x[511:0] - 512'd1; expCnt = 3'd1; expLat = 7;
`endif
      applyStimulus(x, 512'd1, lat);
      checks += 4;
      if (lat !== expLat) begin errors++; $display("[TB] FAIL ripple_latency: got %0d expected %0d", lat, expLat); end
      if (result !== expRes) begin errors++; $display("[TB] FAIL ripple_result: got %0h expected %0h", result, expRes); end
      if (subtracted !== 1'b1) begin errors++; $display("[TB] FAIL ripple_sub: got %0b expected 1", subtracted); end
      if (pass_cnt !== expCnt) begin errors++; $display("[TB] FAIL ripple_pcnt: got %0d expected %0d", pass_cnt, expCnt); end
   endtask

   task automatic test_back_to_back;
      int doneCount;
      int doneCycle;
      int expLat;
      logic [511:0] expRes;
`ifdef MPSUB_ITERATE_EN
      expRes = 512'd6; expLat = 19;
`else
      expRes = 512'd13; expLat = 7;
`endif
      @(negedge clk);
      start = 1'b1;
      in_x  = 514'd20;
      in_m  = 512'd7;
      @(negedge clk);
      doneCount = 0;
      doneCycle = -1;
      for (int c = 1; c <= 45; c++) begin
         if (done === 1'b1) begin
            doneCount++;
            if (doneCount == 1) doneCycle = c;
         end
         // Stray starts with different operands: once mid-operation and once in the done cycle.
         start = (c == 3) || (done === 1'b1);
         if (start) begin
            in_x = 514'd100;
            in_m = 512'd3;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks += 4;
      if (doneCount !== 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", doneCount); end
      if (doneCycle !== expLat) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", doneCycle, expLat); end
      if (result !== expRes) begin errors++; $display("[TB] FAIL b2b_result: got %0h expected %0h", result, expRes); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_idle: got %0b expected 0", busy); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset;
      test_basic;
      test_reset_abort;
      test_no_sub;
      test_equal;
      test_ripple;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
